// File: rtl/l2_arbiter_pkg.sv
// l2_arbiter_pkg: shared types and helpers for the L2 port arbiter
package l2_arbiter_pkg;
  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;
  typedef logic [LINE_W-1:0] lc3b_line;
  typedef logic [ADDR_W-1:0] lc3b_word;
  typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} arb_state_t;
  typedef enum logic {PORT_A, PORT_B} arb_port_t;
  typedef struct packed {
    logic read;
    logic write;
  } l2_cmd_t;
  // read and write together is illegal and is resolved as a write
  function automatic l2_cmd_t to_cmd(logic rd, logic wr);
    return '{read: rd & ~wr, write: wr};
  endfunction
endpackage

// File: rtl/l2_arbiter_if.sv
// l2_arbiter_if: requester ports A/B and the shared L2 port
interface l2_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
);
  logic                  a_read, a_write, a_resp, a_wait;
  logic [ADDR_WIDTH-1:0] a_address;
  logic [LINE_WIDTH-1:0] a_wdata, a_rdata;
  logic                  b_read, b_write, b_resp, b_wait;
  logic [ADDR_WIDTH-1:0] b_address;
  logic [LINE_WIDTH-1:0] b_wdata, b_rdata;
  logic                  l2_read, l2_write, l2_resp;
  logic [ADDR_WIDTH-1:0] l2_address;
  logic [LINE_WIDTH-1:0] l2_wdata, l2_rdata;
  modport slave (
    input  a_read, a_write, a_address, a_wdata,
    input  b_read, b_write, b_address, b_wdata,
    input  l2_resp, l2_rdata,
    output a_resp, a_rdata, a_wait, b_resp, b_rdata, b_wait,
    output l2_read, l2_write, l2_address, l2_wdata
  );
  modport master (
    output a_read, a_write, a_address, a_wdata,
    output b_read, b_write, b_address, b_wdata,
    output l2_resp, l2_rdata,
    input  a_resp, a_rdata, a_wait, b_resp, b_rdata, b_wait,
    input  l2_read, l2_write, l2_address, l2_wdata
  );
endinterface

// File: rtl/l2_arbiter_req_latch.sv
// l2_req_latch: holds the granted command, address and write line stable until L2 responds
module l2_req_latch
  import l2_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  clr,
  input  l2_cmd_t               cmd_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [LINE_WIDTH-1:0] data_in,
  output l2_cmd_t               cmd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [LINE_WIDTH-1:0] data
);
  // capture on grant; only the command is dropped on completion so the L2 strobe ends
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd  <= '0;
      addr <= '0;
      data <= '0;
    end else if (load) begin
      cmd  <= cmd_in;
      addr <= addr_in;
      data <= data_in;
    end else if (clr) begin
      cmd <= '0;
    end
  end
endmodule

// File: rtl/l2_arbiter.sv
// l2_arbiter: serialises L1 I-cache (A) and D-cache (B) requests onto one L2 port
module l2_arbiter
  import l2_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input logic         clk,
  input logic         rst_n,
  l2_arbiter_if.slave bus
);
  arb_state_t state;
  arb_port_t  last_grant;
  l2_cmd_t    cmd, cmd_in;
  logic       a_req, b_req, grant_a, grant_b, done;
  assign a_req   = bus.a_read | bus.a_write;
  assign b_req   = bus.b_read | bus.b_write;
  assign grant_a = state == IDLE && a_req && (!b_req || last_grant == PORT_B);
  assign grant_b = state == IDLE && b_req && !grant_a;
  assign done    = bus.l2_resp && state != IDLE;
  assign cmd_in  = grant_a ? to_cmd(bus.a_read, bus.a_write) : to_cmd(bus.b_read, bus.b_write);
  // grant from IDLE, return to IDLE on the L2 response and remember who was served
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= PORT_A;
    end else if (grant_a) begin
      state <= SERVE_A;
    end else if (grant_b) begin
      state <= SERVE_B;
    end else if (done) begin
      state      <= IDLE;
      last_grant <= state == SERVE_A ? PORT_A : PORT_B;
    end
  end
  l2_req_latch #(.ADDR_WIDTH(ADDR_WIDTH), .LINE_WIDTH(LINE_WIDTH)) u_latch (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (grant_a | grant_b),
    .clr    (done),
    .cmd_in (cmd_in),
    .addr_in(grant_a ? bus.a_address : bus.b_address),
    .data_in(grant_a ? bus.a_wdata : bus.b_wdata),
    .cmd    (cmd),
    .addr   (bus.l2_address),
    .data   (bus.l2_wdata)
  );
  assign bus.l2_read  = cmd.read;
  assign bus.l2_write = cmd.write;
  assign bus.a_resp   = state == SERVE_A && bus.l2_resp;
  assign bus.b_resp   = state == SERVE_B && bus.l2_resp;
  assign bus.a_rdata  = bus.l2_rdata;
  assign bus.b_rdata  = bus.l2_rdata;
  assign bus.a_wait   = a_req & ~bus.a_resp;
  assign bus.b_wait   = b_req & ~bus.b_resp;
endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: randomized requesters and L2 responder against a transaction-level arbitration model
module tb_l2_arbiter;
  import l2_arbiter_pkg::*;
  localparam int AW = 16;
  localparam int LW = 128;
  typedef struct {
    int            port;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
    int            cyc;
  } cmd_exp_t;
  typedef struct {
    int            port;
    logic [LW-1:0] data;
  } resp_exp_t;

  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;

  l2_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus();
  l2_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  cmd_exp_t  cq[$];
  resp_exp_t rq[$];
  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  logic          rd[2], wr[2];
  logic [AW-1:0] ad[2];
  logic [LW-1:0] wd[2];
  bit spur = 0;
  bit m_busy = 0;
  bit resp_pend = 0;
  bit l2_busy = 0;
  int m_owner = 0;
  int m_last = 0;
  int l2_wait = 0;
  bit prev_act = 0;
  cmd_exp_t cur;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [LW-1:0] got, logic [LW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [LW-1:0] rline();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive();
    bus.a_read = rd[0]; bus.a_write = wr[0]; bus.a_address = ad[0]; bus.a_wdata = wd[0];
    bus.b_read = rd[1]; bus.b_write = wr[1]; bus.b_address = ad[1]; bus.b_wdata = wd[1];
  endtask

  // one cycle of environment: retire, L2 behaviour, requesters, then the arbitration decision
  task automatic step(int den, bit mutate);
    logic [LW-1:0] line;
    bit ra, rb;
    int w, k;
    if (resp_pend) begin
      rd[m_owner] = 0;
      wr[m_owner] = 0;
      m_busy = 0;
      m_last = m_owner;
      resp_pend = 0;
    end
    bus.l2_resp = 0;
    spur = 0;
    if (l2_busy) begin
      if (l2_wait == 0) begin
        line = rline();
        bus.l2_rdata = line;
        bus.l2_resp = 1;
        rq.push_back('{m_owner, line});
        l2_busy = 0;
        resp_pend = 1;
      end else l2_wait--;
    end else if (bus.l2_read | bus.l2_write) begin
      l2_busy = 1;
      l2_wait = $urandom_range(0, 4);
    end else if ($urandom_range(0, 9) == 0) begin
      bus.l2_resp = 1;
      bus.l2_rdata = rline();
      spur = 1;
    end
    for (int p = 0; p < 2; p++) begin
      if (!(rd[p] | wr[p]) && den != 0 && $urandom_range(0, den - 1) == 0) begin
        k = $urandom_range(0, 7);
        rd[p] = k != 0 && k < 4 || k == 0;
        wr[p] = k >= 4 || k == 0;
        ad[p] = AW'($urandom);
        wd[p] = rline();
      end else if (mutate && m_busy && p == m_owner && $urandom_range(0, 2) == 0) begin
        ad[p] = AW'($urandom);
        wd[p] = rline();
      end
    end
    drive();
    ra = rd[0] | wr[0];
    rb = rd[1] | wr[1];
    if (!m_busy && (ra || rb)) begin
      w = ra && (!rb || m_last == 1) ? 0 : 1;
      cq.push_back('{w, rd[w] & ~wr[w], wr[w], ad[w], wd[w], cyc + 1});
      m_busy = 1;
      m_owner = w;
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    for (int p = 0; p < 2; p++) begin rd[p] = 0; wr[p] = 0; ad[p] = '0; wd[p] = '0; end
    drive();
    bus.l2_resp = 0;
    bus.l2_rdata = '0;
    spur = 0;
    cq.delete();
    rq.delete();
    m_busy = 0;
    m_last = 0;
    resp_pend = 0;
    l2_busy = 0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_l2_read", bus.l2_read, 0);
    chk("rst_l2_write", bus.l2_write, 0);
    chk("rst_l2_address", bus.l2_address, 0);
    chk("rst_l2_wdata", bus.l2_wdata, 0);
    chk("rst_a_resp", bus.a_resp, 0);
    chk("rst_b_resp", bus.b_resp, 0);
    chk("rst_a_wait", bus.a_wait, 0);
    chk("rst_b_wait", bus.b_wait, 0);
  endtask

  // monitor: pops expectations whenever the DUT starts an L2 command or the L2 responds
  always @(negedge clk) begin
    automatic bit act = bus.l2_read | bus.l2_write;
    automatic bit ea = 0;
    automatic bit eb = 0;
    resp_exp_t r;
    if (rst_n) begin
      if (act && !prev_act) begin
        if (cq.size() == 0) chk("unexpected_cmd", 1, 0);
        else begin
          cur = cq.pop_front();
          chk("grant_cycle", LW'(cyc), LW'(cur.cyc));
          chk("l2_read", bus.l2_read, cur.rd);
          chk("l2_write", bus.l2_write, cur.wr);
          chk("l2_address", bus.l2_address, cur.addr);
          chk("l2_wdata", bus.l2_wdata, cur.data);
        end
      end else if (act) begin
        chk("addr_hold", bus.l2_address, cur.addr);
        chk("wdata_hold", bus.l2_wdata, cur.data);
      end
      if (bus.l2_resp && !spur) begin
        if (rq.size() == 0) chk("unexpected_resp", 1, 0);
        else begin
          r = rq.pop_front();
          ea = r.port == 0;
          eb = r.port == 1;
          if (ea) chk("a_rdata", bus.a_rdata, r.data);
          else chk("b_rdata", bus.b_rdata, r.data);
        end
      end
      chk("a_resp", bus.a_resp, ea);
      chk("b_resp", bus.b_resp, eb);
      chk("a_wait", bus.a_wait, (rd[0] | wr[0]) & ~ea);
      chk("b_wait", bus.b_wait, (rd[1] | wr[1]) & ~eb);
    end
    prev_act = act;
  end

  initial begin
    do_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1;
    @(posedge clk); #1;
    bus.l2_resp = 1;
    bus.l2_rdata = rline();
    spur = 1;
    @(posedge clk); #1;
    rd[0] = 1; ad[0] = 16'h1230; wd[0] = rline();
    wr[1] = 1; ad[1] = 16'h4000; wd[1] = rline();
    step(0, 0);
    repeat (80) begin @(posedge clk); #1; step(1, 1); end
    repeat (2000) begin @(posedge clk); #1; step(3, 1); end
    for (int i = 0; i < 100 && !(bus.l2_read | bus.l2_write); i++) begin
      @(posedge clk); #1; step(3, 0);
    end
    chk("reach_serve", bus.l2_read | bus.l2_write, 1);
    do_reset();
    @(posedge clk); #1;
    chk_reset_outputs();
    rst_n = 1;
    @(posedge clk); #1;
    wr[0] = 1; ad[0] = 16'h2222; wd[0] = rline();
    rd[1] = 1; ad[1] = 16'h5000; wd[1] = rline();
    step(0, 0);
    repeat (1000) begin @(posedge clk); #1; step(4, 1); end
    for (int i = 0; i < 300 && (m_busy || cq.size() != 0 || rq.size() != 0); i++) begin
      @(posedge clk); #1; step(0, 0);
    end
    @(negedge clk);
    chk("drain_left", LW'(cq.size() + rq.size() + int'(m_busy)), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Two-port arbiter sharing the single unified L2 cache port between the L1 instruction cache (port A) and the L1 data cache (port B). It sits below both L1 caches. It serialises their line-fill and write-back requests onto one L2 interface, latching each granted request so that it stays stable until the L2 responds. It also exports per-port wait flags that the pipeline stall logic uses, alongside the write-back latch's cache-miss stall input.

## Interface
Parameters:
- ADDR_WIDTH, default 16, byte address width (lc3b_word).
- LINE_WIDTH, default 128, cache-line width (lc3b_line).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- a_read, a_write  in  1  port A request; at most one high.
- a_address  in  ADDR_WIDTH  port A line address.
- a_wdata  in  LINE_WIDTH  port A write line.
- a_resp  out  1  port A done, one cycle.
- a_rdata  out  LINE_WIDTH  port A read line, valid with a_resp.
- b_read, b_write, b_address, b_wdata, b_resp, b_rdata  same as port A, for port B.
- a_wait, b_wait  out  1  request pending on that port and not being responded to this cycle.
- l2_read, l2_write  out  1  L2 command.
- l2_address  out  ADDR_WIDTH  latched address.
- l2_wdata  out  LINE_WIDTH  latched write line.
- l2_resp  in  1  L2 done, one cycle.
- l2_rdata  in  LINE_WIDTH  L2 read line.

## Operation
- FSM states: IDLE, SERVE_A, SERVE_B.
- Port request: X_req = X_read | X_write.
- In IDLE, only A requesting: go to SERVE_A.
- In IDLE, only B requesting: go to SERVE_B.
- In IDLE, both requesting: grant the port not granted last, tracked by a last_grant register; reset value = A, so B wins the first tie.
- On a grant edge, latch the winner's command, address and wdata into cmd/addr/data registers. l2_* outputs are driven only from these registers.
- In SERVE_X, l2_read or l2_write is asserted per the latched command until l2_resp.
- On l2_resp in SERVE_X:
  - X_resp = 1 combinationally.
  - X_rdata = l2_rdata.
  - Next state is IDLE.
  - last_grant updates to X.
- The other port never sees resp.
- A requester that drops or changes its request mid-transaction has no effect. The latched transaction completes and its response is still pulsed.
- a_wait = a_req & ~(state==SERVE_A & l2_resp); b_wait likewise.
- l2_resp outside SERVE_A/SERVE_B is ignored.
- a_read & a_write both high is illegal; the arbiter treats it as a write.
- X_rdata is driven from l2_rdata at all times; it is only meaningful with X_resp.

## Timing
- Reset (rst_n low at a clock edge):
  - state = IDLE, last_grant = A.
  - cmd/addr/data registers cleared.
  - All outputs 0.
- Reset wins over any in-flight transaction. L2 must be reset in the same cycle.
- Grant latency: request seen in IDLE at edge N gives l2_read/l2_write high in the cycle after edge N.
- Requester response: X_resp is in the same cycle as l2_resp (zero added latency).
- Turnaround: at least one IDLE cycle between consecutive transactions, so back-to-back requests are issued at best every L2 latency + 1 cycles.
- Requesters must hold read/write until their resp, and deassert in the cycle after resp. A request still high in the IDLE cycle after resp is a new request.
- Starvation: under continuous contention, grants strictly alternate A, B, A, B…

## Structure
- lc3b_types holds:
  - lc3b_line (128-bit) and lc3b_word.
  - arb_state_t enum {IDLE, SERVE_A, SERVE_B}.
  - arb_port_t {PORT_A, PORT_B}.
- One sub-module is natural: l2_req_latch. It holds the cmd/addr/data registers with load = grant, built from the existing register module with a width parameter.
- FSM and wait/resp steering live in l2_arbiter.

## Test plan
- Single read: reset, then a_read=1, a_address=0x1230. l2_read=1 one cycle later with l2_address=0x1230. L2 returns l2_resp with l2_rdata=0xDEAD…BEEF after 5 cycles. a_resp pulses with that data in the same cycle; b_resp stays 0.
- Tie after reset: a_read and b_write (b_address=0x4000) assert in the same cycle. B is served first (l2_write, l2_address=0x4000). A is served next, with a_wait high throughout B's transaction.
- Alternation: both ports request continuously for 6 transactions. The grant order is B, A, B, A, B, A, with exactly one IDLE cycle between transactions.
- Latch stability: b_address changes 0x4000→0x5000 mid-transaction. l2_address holds 0x4000 until l2_resp.
- Reset mid-operation: rst_n=0 while in SERVE_A. The next cycle has all outputs 0 and state IDLE. After release, a tie is again granted to B.
- Spurious response: l2_resp=1 while IDLE. There is no a_resp/b_resp and no state change.
